// File: rtl/demo_qsys_button_input.sv
// demo_qsys_button_input: Avalon-MM parallel-input peripheral.
// Synchronises and debounces WIDTH button inputs, captures debounced edges
// into a sticky write-1-to-clear register and raises a maskable level irq.
// Register map (word address): 0 DATA, 1 RAW, 2 IRQMASK, 3 EDGECAP.

module demo_qsys_button_input #(
    parameter int WIDTH           = 4,      // number of input bits (1..32)
    parameter int DEBOUNCE_CYCLES = 50000,  // stable cycles needed to accept a level
    parameter int EDGE_TYPE       = 0       // 0 rising, 1 falling, 2 any
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    typedef enum logic [1:0] {
        REG_DATA    = 2'd0,
        REG_RAW     = 2'd1,
        REG_IRQMASK = 2'd2,
        REG_EDGECAP = 2'd3
    } reg_addr_e;

    // Counter only has to reach DEBOUNCE_CYCLES-1, so clog2 bits suffice.
    localparam int              CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] raw;
    logic [WIDTH-1:0] db;
    logic [CNT_W-1:0] cnt [WIDTH];
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] edge_cap;

    logic [WIDTH-1:0] accept;
    logic [WIDTH-1:0] rise_evt;
    logic [WIDTH-1:0] fall_evt;
    logic [WIDTH-1:0] cap_evt;
    logic [WIDTH-1:0] w1c;
    logic             wr_en;
    logic [31:0]      rd_mux;

    // Upper writedata bits are architecturally ignored; fold them here so
    // the unused-bit warning is silenced by the signal name alone.
    logic unused_wdata;
    assign unused_wdata = ^writedata;

    assign wr_en = chipselect && !write_n;

    // Debounce events and write-1-to-clear mask for the current cycle.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned, which would infer a latch.
        accept   = '0;
        cap_evt  = '0;
        w1c      = '0;
        for (int i = 0; i < WIDTH; i++) begin
            accept[i] = (raw[i] != db[i]) && (cnt[i] == CNT_LAST);
        end
        rise_evt = accept & raw;
        fall_evt = accept & ~raw;
        case (EDGE_TYPE)
            0:       cap_evt = rise_evt;
            1:       cap_evt = fall_evt;
            default: cap_evt = rise_evt | fall_evt;
        endcase
        if (wr_en && (reg_addr_e'(address) == REG_EDGECAP)) begin
            w1c = writedata[WIDTH-1:0];
        end
    end

    // Two-flop synchroniser for the asynchronous pins.
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values; blocking here would collapse the chain.
        if (!reset_n) begin
            sync1 <= '0;
            raw   <= '0;
        end else begin
            sync1 <= in_port;
            raw   <= sync1;
        end
    end

    // Per-bit debouncer: accept a new level after DEBOUNCE_CYCLES stable cycles.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: cnt is an array of ordinary flops, not a RAM, so it is
            // reset like any other state; an aborted debounce must not resume.
            db <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (raw[i] == db[i]) begin
                    cnt[i] <= '0;
                end else if (accept[i]) begin
                    db[i]  <= raw[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // Interrupt mask and sticky edge capture; a new event beats a same-cycle clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_mask <= '0;
            edge_cap <= '0;
        end else begin
            if (wr_en && (reg_addr_e'(address) == REG_IRQMASK)) begin
                irq_mask <= writedata[WIDTH-1:0];
            end
            edge_cap <= (edge_cap & ~w1c) | cap_evt;
        end
    end

    // Read multiplexer, zero-extended to the 32-bit bus.
    always_comb begin
        rd_mux = '0;
        case (reg_addr_e'(address))
            REG_DATA:    rd_mux[WIDTH-1:0] = db;
            REG_RAW:     rd_mux[WIDTH-1:0] = raw;
            REG_IRQMASK: rd_mux[WIDTH-1:0] = irq_mask;
            REG_EDGECAP: rd_mux[WIDTH-1:0] = edge_cap;
            default:     rd_mux = '0;
        endcase
    end

    // Registered read data, updated every cycle with one cycle of latency.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
        end else begin
            readdata <= rd_mux;
        end
    end

    // Level interrupt straight from registers, so it cannot glitch.
    assign irq = |(edge_cap & irq_mask);

endmodule

// File: tb/tb_demo_qsys_button_input.sv
// Testbench for demo_qsys_button_input: three instances (rising, falling,
// any-edge capture) share stimulus; expected responses are queued by the
// stimulus tasks and compared by an independent monitor.

module tb_demo_qsys_button_input;

    localparam int W = 4;
    localparam int D = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [1:0]    address;
    logic          chipselect;
    logic          write_n;
    logic [31:0]   writedata;
    logic [W-1:0]  in_port;
    logic [31:0]   rd0, rd1, rd2;
    logic          irq0, irq1, irq2;

    always #5 clk = ~clk;

    demo_qsys_button_input #(.WIDTH(W), .DEBOUNCE_CYCLES(D), .EDGE_TYPE(0)) u_rise (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rd0), .irq(irq0)
    );

    demo_qsys_button_input #(.WIDTH(W), .DEBOUNCE_CYCLES(D), .EDGE_TYPE(1)) u_fall (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rd1), .irq(irq1)
    );

    demo_qsys_button_input #(.WIDTH(W), .DEBOUNCE_CYCLES(D), .EDGE_TYPE(2)) u_any (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rd2), .irq(irq2)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Scoreboard: kind 0 = readdata, kind 1 = irq; dut 0 rise, 1 fall, 2 any.
    logic [31:0] exp_q  [$];
    int          kind_q [$];
    int          dut_q  [$];
    string       name_q [$];

    logic req_valid = 1'b0;
    logic req_seen  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] dut_out(input int kind, input int dut);
        logic [31:0] v;
        v = '0;
        case (dut)
            0:       v = (kind == 1) ? {31'd0, irq0} : rd0;
            1:       v = (kind == 1) ? {31'd0, irq1} : rd1;
            default: v = (kind == 1) ? {31'd0, irq2} : rd2;
        endcase
        return v;
    endfunction

    // A request issued before edge n is answered by the DUT after edge n.
    always @(posedge clk) req_seen <= req_valid;

    // Monitor: pop one expectation per answered request.
    always @(negedge clk) begin
        if (req_seen) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL scoreboard_underflow: got a response, expected none queued");
            end else begin
                check(name_q.pop_front(),
                      dut_out(kind_q.pop_front(), dut_q.pop_front()),
                      exp_q.pop_front());
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_resp(input int kind, input int dut, input logic [1:0] addr,
                               input logic [31:0] exp, input string name);
        address = addr;
        exp_q.push_back(exp);
        kind_q.push_back(kind);
        dut_q.push_back(dut);
        name_q.push_back(name);
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic rd(input logic [1:0] addr, input int dut, input logic [31:0] exp,
                      input string name);
        expect_resp(0, dut, addr, exp, name);
    endtask

    task automatic irq_chk(input int dut, input logic exp, input string name);
        expect_resp(1, dut, address, {31'd0, exp}, name);
    endtask

    task automatic wr(input logic [1:0] addr, input logic [31:0] data);
        address    = addr;
        writedata  = data;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n    = 1'b0;
        in_port    = 4'hF;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'd0;
        step(2);

        // Everything reads zero while reset is held, even with pins high.
        rd(2'd0, 0, 32'h0, "rst_data");
        rd(2'd1, 0, 32'h0, "rst_raw");
        rd(2'd2, 0, 32'h0, "rst_mask");
        rd(2'd3, 0, 32'h0, "rst_edgecap");
        irq_chk(0, 1'b0, "rst_irq");

        // Pins held high through release: db changes at edge k+5, visible in
        // readdata captured at k+6.
        reset_n = 1'b1;
        for (int j = 0; j <= 6; j++) begin
            rd(2'd0, 0, (j < 6) ? 32'h0 : 32'hF, $sformatf("rel_data_%0d", j));
        end
        rd(2'd3, 0, 32'hF, "rel_edgecap_rise");
        rd(2'd3, 1, 32'h0, "rel_edgecap_fall");
        rd(2'd3, 2, 32'hF, "rel_edgecap_any");
        irq_chk(0, 1'b0, "rel_irq_masked");

        in_port = 4'h0;
        step(10);
        wr(2'd3, 32'hF);
        rd(2'd3, 0, 32'h0, "init_clear_rise");
        rd(2'd3, 1, 32'h0, "init_clear_fall");
        rd(2'd3, 2, 32'h0, "init_clear_any");

        // Three-cycle glitch is shorter than the debounce window.
        in_port = 4'h1;
        step(3);
        in_port = 4'h0;
        step(8);
        rd(2'd0, 0, 32'h0, "glitch_data");
        rd(2'd3, 0, 32'h0, "glitch_edgecap");
        rd(2'd3, 2, 32'h0, "glitch_edgecap_any");

        // Six-cycle pulse is accepted at edge k+5.
        in_port = 4'h1;
        for (int j = 0; j <= 6; j++) begin
            if (j == 6) in_port = 4'h0;
            rd(2'd0, 0, (j < 6) ? 32'h0 : 32'h1, $sformatf("pulse_data_%0d", j));
        end
        rd(2'd3, 0, 32'h1, "pulse_edgecap");
        step(10);
        wr(2'd3, 32'hF);

        // Interrupt masking and clearing.
        wr(2'd2, 32'h2);
        in_port = 4'h2;
        step(8);
        irq_chk(0, 1'b1, "irq_rise_b1");
        rd(2'd3, 0, 32'h2, "irq_edgecap_b1");
        wr(2'd3, 32'h2);
        irq_chk(0, 1'b0, "irq_after_w1c");
        in_port = 4'h3;
        step(8);
        irq_chk(0, 1'b0, "irq_unmasked_b0");
        rd(2'd3, 0, 32'h1, "irq_edgecap_b0");
        in_port = 4'h0;
        step(8);
        wr(2'd3, 32'hF);

        // Clear of bits 0 and 2 lands on the same edge bit 2 is accepted.
        in_port = 4'h1;
        step(8);
        rd(2'd3, 0, 32'h1, "coll_pre");
        in_port = 4'h5;
        step(5);
        wr(2'd3, 32'h5);
        rd(2'd3, 0, 32'h4, "coll_set_wins");

        // Edge selection on bit 3: rise then fall.
        wr(2'd3, 32'hF);
        in_port = 4'hD;
        step(8);
        rd(2'd3, 0, 32'h8, "b3_rise_rise");
        rd(2'd3, 1, 32'h0, "b3_rise_fall");
        rd(2'd3, 2, 32'h8, "b3_rise_any");
        wr(2'd3, 32'hF);
        in_port = 4'h5;
        step(8);
        rd(2'd3, 0, 32'h0, "b3_fall_rise");
        rd(2'd3, 1, 32'h8, "b3_fall_fall");
        rd(2'd3, 2, 32'h8, "b3_fall_any");
        wr(2'd3, 32'hF);

        // Register access: mask width, read-only registers ignore writes.
        wr(2'd2, 32'hFFFF_FFFF);
        rd(2'd2, 0, 32'h0000_000F, "mask_width");
        wr(2'd0, 32'hFFFF_FFFF);
        wr(2'd1, 32'hFFFF_FFFF);
        rd(2'd0, 0, 32'h5, "data_ro");
        rd(2'd1, 0, 32'h5, "raw_ro");
        irq_chk(0, 1'b0, "irq_none_pending");

        // RAW follows the pin after two edges, DATA after the debounce window.
        in_port = 4'h0;
        for (int j = 0; j <= 6; j++) begin
            if (j < 3) rd(2'd1, 0, (j < 2) ? 32'h5 : 32'h0, $sformatf("lag_raw_%0d", j));
            else       rd(2'd0, 0, (j < 6) ? 32'h5 : 32'h0, $sformatf("lag_data_%0d", j));
        end
        in_port = 4'h1;
        step(8);
        irq_chk(0, 1'b1, "irq_mask_all");

        // Reset in the middle of a debounce discards everything.
        in_port = 4'h3;
        step(3);
        reset_n = 1'b0;
        step(2);
        reset_n = 1'b1;
        rd(2'd2, 0, 32'h0, "rst2_mask");
        rd(2'd0, 0, 32'h0, "rst2_data");
        rd(2'd3, 0, 32'h0, "rst2_edgecap");
        irq_chk(0, 1'b0, "rst2_irq");

        step(2);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
